if1_pcgen: RTL and testbench

Fetch PC generator for IF1. Holds the fetch program counter that drives the BTB lookup and selects the next PC each cycle. It combines the BTB's combinational prediction, a return address stack (RAS), decode corrections and commit flushes. It registers the predicted fetch block into an IF2 pipeline register using a valid/ready handshake.

---
 rtl/calvera_fe_pkg.sv | 19 +
 rtl/if1_pcgen_if.sv | 26 ++
 rtl/ras.sv | 47 ++++
 rtl/if1_pcgen.sv | 101 ++++++++++
 tb/tb_if1_pcgen.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/calvera_fe_pkg.sv
// calvera_fe_pkg: shared front-end types for the IF1 fetch PC generator.
// Holds the BTB branch-type enum, the PC generator FSM states, fetch geometry
// constants and the IF2 pipeline packet.
package calvera_fe_pkg;
  typedef enum logic [1:0] {BR_COND, BR_CALL, BR_JUMP, BR_RET} btype_t;
  typedef enum logic [1:0] {ST_RESET, ST_BOOT, ST_RUN} pcgen_state_t;
  localparam int FETCH_BYTES = 8;
  localparam int RAS_PTR_W = 5;
  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          target;
    logic                 taken;
    btype_t               btype;
    logic [1:0]           bm;
    logic                 way;
    logic                 slot;
    logic [RAS_PTR_W-1:0] ras_ptr;
  } if2_pkt_t;
endpackage

// File: rtl/if1_pcgen_if.sv
// if1_pcgen_if: IF1 -> IF2 valid/ready handshake carrying the predicted fetch block.
// master (PC generator): drives if2_valid_o and all if2_* data, samples if2_ready_i.
// slave (IF2 consumer): samples the block, drives if2_ready_i.
interface if1_pcgen_if;
  import calvera_fe_pkg::*;
  logic                 if2_valid_o;
  logic                 if2_ready_i;
  logic [31:0]          if2_pc_o;
  logic [31:0]          if2_pred_target_o;
  logic                 if2_pred_taken_o;
  logic [1:0]           if2_btype_o;
  logic [1:0]           if2_bm_o;
  logic                 if2_way_o;
  logic                 if2_slot_o;
  logic [RAS_PTR_W-1:0] if2_ras_ptr_o;
  modport master (
    output if2_valid_o, if2_pc_o, if2_pred_target_o, if2_pred_taken_o,
           if2_btype_o, if2_bm_o, if2_way_o, if2_slot_o, if2_ras_ptr_o,
    input  if2_ready_i
  );
  modport slave (
    input  if2_valid_o, if2_pc_o, if2_pred_target_o, if2_pred_taken_o,
           if2_btype_o, if2_bm_o, if2_way_o, if2_slot_o, if2_ras_ptr_o,
    output if2_ready_i
  );
endinterface

// File: rtl/ras.sv
// ras: circular return address stack with push/pop, pointer restore and occupancy count.
// Ports: clk/rst, push/pop/push_addr, restore/restore_ptr, top (entry below ptr),
// hit (stack non-empty), ptr_nxt (pointer after this cycle's push/pop).
// A push when full overwrites the oldest entry; a pop when empty is a no-op.
module ras
  import calvera_fe_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [31:0]          push_addr,
  input  logic                 restore,
  input  logic [RAS_PTR_W-1:0] restore_ptr,
  output logic [31:0]          top,
  output logic                 hit,
  output logic [RAS_PTR_W-1:0] ptr_nxt
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [IW-1:0] ptr, pn;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];
  logic          pop_ok;
  always_comb begin
    hit = cnt != '0;
    top = mem[ptr - IW'(1)];
    pop_ok = pop & hit;
    pn = push ? ptr + IW'(1) : pop_ok ? ptr - IW'(1) : ptr;
    ptr_nxt = RAS_PTR_W'(pn);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      mem <= '{default: '0};
    end else if (restore) begin
      ptr <= restore_ptr[IW-1:0];
    end else begin
      ptr <= pn;
      if (push) mem[ptr] <= push_addr;
      cnt <= push ? (cnt == CW'(DEPTH) ? cnt : cnt + CW'(1)) : pop_ok ? cnt - CW'(1) : cnt;
    end
  end
endmodule

// File: rtl/if1_pcgen.sv
// if1_pcgen: IF1 fetch PC generator with BTB prediction, optional RAS and IF2 register.
// Ports: cpu_clk_i/reset_i (sync, active-high); c1_flush_* commit redirect with RAS
// checkpoint; dec_redirect_* decode redirect; btb_* combinational BTB lookup of
// if1_current_pc_o; if1_valid_o; if2 (if1_pcgen_if.master) valid/ready IF2 packet.
// Build option: define CALVERA_PCGEN_RAS_EN to instantiate the return address stack;
// without it returns predict the BTB target and if2_ras_ptr_o stays 0.
// Reset holds the FSM in BOOT; BOOT spends one cycle with if1_valid_o low, then RUN.
module if1_pcgen
  import calvera_fe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 8
) (
  input  logic                 cpu_clk_i,
  input  logic                 reset_i,
  input  logic                 c1_flush_i,
  input  logic [31:0]          c1_flush_pc_i,
  input  logic [RAS_PTR_W-1:0] c1_ras_ptr_i,
  input  logic                 dec_redirect_i,
  input  logic [31:0]          dec_redirect_pc_i,
  input  logic                 btb_vld_i,
  input  logic [1:0]           btb_btype_i,
  input  logic [1:0]           btb_bm_pred_i,
  input  logic [31:0]          btb_target_i,
  input  logic                 btb_index_i,
  input  logic                 btb_way_present_i,
  output logic [31:0]          if1_current_pc_o,
  output logic                 if1_valid_o,
  if1_pcgen_if.master          if2
);
  pcgen_state_t         state;
  if2_pkt_t             pkt, pkt_d;
  btype_t               bt;
  logic [31:0]          pc, seq_pc, tgt, nxt, ras_top;
  logic                 v2, taken, is_ret, adv, ras_hit;
  logic [RAS_PTR_W-1:0] ras_ptr;
  always_comb begin
    bt = btype_t'(btb_btype_i);
    seq_pc = {pc[31:3], 3'b000} + 32'(FETCH_BYTES);
    taken = btb_vld_i & (bt != BR_COND | btb_bm_pred_i[1]);
    is_ret = btb_vld_i & (bt == BR_RET);
    tgt = is_ret & ras_hit ? ras_top : btb_target_i;
    nxt = taken ? tgt : seq_pc;
    // a redirect squashes this cycle's prediction, so it never advances or touches the RAS
    adv = if1_valid_o & (!v2 | if2.if2_ready_i) & !c1_flush_i & !dec_redirect_i;
    pkt_d = '{pc: pc, target: nxt, taken: taken, btype: bt, bm: btb_bm_pred_i,
              way: btb_way_present_i, slot: btb_index_i, ras_ptr: ras_ptr};
  end
`ifdef CALVERA_PCGEN_RAS_EN
  logic [31:0] call_ret;
  assign call_ret = {pc[31:3], btb_index_i, 2'b00} + 32'd4;
  ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (cpu_clk_i),
    .rst         (reset_i),
    .push        (adv & btb_vld_i & (bt == BR_CALL)),
    .pop         (adv & is_ret),
    .push_addr   (call_ret),
    .restore     (c1_flush_i & (state == ST_RUN)),
    .restore_ptr (c1_ras_ptr_i),
    .top         (ras_top),
    .hit         (ras_hit),
    .ptr_nxt     (ras_ptr)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{c1_ras_ptr_i, RAS_DEPTH[0]};
  assign ras_top = '0;
  assign ras_hit = 1'b0;
  assign ras_ptr = '0;
`endif
  always_ff @(posedge cpu_clk_i) begin
    if (reset_i) begin
      state <= ST_BOOT;
      pc <= RESET_PC;
      if1_valid_o <= 1'b0;
      v2 <= 1'b0;
      pkt <= '0;
    end else if (state == ST_BOOT) begin
      state <= ST_RUN;
      pc <= RESET_PC;
      if1_valid_o <= 1'b1;
    end else if (c1_flush_i | dec_redirect_i) begin
      pc <= c1_flush_i ? c1_flush_pc_i : dec_redirect_pc_i;
      v2 <= 1'b0;
    end else if (adv) begin
      pc <= nxt;
      v2 <= 1'b1;
      pkt <= pkt_d;
    end
  end
  assign if1_current_pc_o = pc;
  assign if2.if2_valid_o = v2;
  assign if2.if2_pc_o = pkt.pc;
  assign if2.if2_pred_target_o = pkt.target;
  assign if2.if2_pred_taken_o = pkt.taken;
  assign if2.if2_btype_o = pkt.btype;
  assign if2.if2_bm_o = pkt.bm;
  assign if2.if2_way_o = pkt.way;
  assign if2.if2_slot_o = pkt.slot;
  assign if2.if2_ras_ptr_o = pkt.ras_ptr;
endmodule

// File: tb/tb_if1_pcgen.sv
// tb_if1_pcgen: directed and randomized self-checking bench for if1_pcgen against a behavioural model.
module tb_if1_pcgen;
  import calvera_fe_pkg::*;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int D = 8;
`ifdef CALVERA_PCGEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush, dec, vld, idx, way;
  logic [31:0] flush_pc, dec_pc, tgt, pc_o;
  logic [4:0] flush_ptr;
  logic [1:0] bt, bm;
  logic if1v_o;
  int total = 0;
  int bad = 0;
  bit chk = 1'b0;
  if1_pcgen_if ifc ();
  if1_pcgen #(.RESET_PC(RPC), .RAS_DEPTH(D)) dut (
    .cpu_clk_i(clk), .reset_i(rst),
    .c1_flush_i(flush), .c1_flush_pc_i(flush_pc), .c1_ras_ptr_i(flush_ptr),
    .dec_redirect_i(dec), .dec_redirect_pc_i(dec_pc),
    .btb_vld_i(vld), .btb_btype_i(bt), .btb_bm_pred_i(bm), .btb_target_i(tgt),
    .btb_index_i(idx), .btb_way_present_i(way),
    .if1_current_pc_o(pc_o), .if1_valid_o(if1v_o), .if2(ifc)
  );
  always #5 clk = ~clk;
  bit m_boot, m_if1v, m_if2v, m_tk, m_way, m_slot;
  logic [31:0] m_pc, m_ipc, m_itgt;
  logic [1:0] m_bt, m_bm;
  logic [4:0] m_ptr;
  logic [31:0] rm [D];
  int rp, rc;
  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic step();
    bit tk;
    logic [31:0] t, seq;
    if (rst) begin
      m_boot = 1; m_pc = RPC; m_if1v = 0; m_if2v = 0;
      m_ipc = 0; m_itgt = 0; m_tk = 0; m_bt = 0; m_bm = 0; m_way = 0; m_slot = 0; m_ptr = 0;
      rp = 0; rc = 0;
      foreach (rm[i]) rm[i] = 0;
    end else if (m_boot) begin
      m_boot = 0; m_pc = RPC; m_if1v = 1;
    end else if (flush || dec) begin
      m_pc = flush ? flush_pc : dec_pc;
      m_if2v = 0;
      if (flush) rp = int'(flush_ptr) % D;
    end else if (m_if1v && (!m_if2v || ifc.if2_ready_i)) begin
      tk = vld && (bt != 2'd0 || bm[1]);
      t = tgt;
      seq = (m_pc & ~32'd7) + 32'd8;
      if (RAS_EN && vld && bt == 2'd3 && rc > 0) t = rm[(rp + D - 1) % D];
      if (RAS_EN && vld && bt == 2'd1) begin
        rm[rp] = {m_pc[31:3], idx, 2'b00} + 32'd4;
        rp = (rp + 1) % D;
        if (rc < D) rc++;
      end else if (RAS_EN && vld && bt == 2'd3 && rc > 0) begin
        rp = (rp + D - 1) % D;
        rc--;
      end
      m_ipc = m_pc; m_itgt = tk ? t : seq; m_tk = tk; m_bt = bt; m_bm = bm;
      m_way = way; m_slot = idx; m_ptr = RAS_EN ? 5'(rp) : 5'd0;
      m_pc = tk ? t : seq;
      m_if2v = 1;
    end
  endtask
  always @(negedge clk) if (chk) begin
    cmp("pc", pc_o, m_pc);
    cmp("if1_valid", 32'(if1v_o), 32'(m_if1v));
    cmp("if2_valid", 32'(ifc.if2_valid_o), 32'(m_if2v));
    cmp("if2_pc", ifc.if2_pc_o, m_ipc);
    cmp("if2_target", ifc.if2_pred_target_o, m_itgt);
    cmp("if2_taken", 32'(ifc.if2_pred_taken_o), 32'(m_tk));
    cmp("if2_btype", 32'(ifc.if2_btype_o), 32'(m_bt));
    cmp("if2_bm", 32'(ifc.if2_bm_o), 32'(m_bm));
    cmp("if2_way", 32'(ifc.if2_way_o), 32'(m_way));
    cmp("if2_slot", 32'(ifc.if2_slot_o), 32'(m_slot));
    cmp("if2_ras_ptr", 32'(ifc.if2_ras_ptr_o), 32'(m_ptr));
  end
  task automatic tick();
    @(posedge clk);
    step();
    #1;
  endtask
  task automatic idle();
    flush = 0; dec = 0; vld = 0; bt = 0; bm = 0; idx = 0; way = 0;
    flush_pc = 0; dec_pc = 0; flush_ptr = 0; tgt = 0;
  endtask
  task automatic redirect(input logic [31:0] p);
    dec = 1; dec_pc = p;
    tick();
    dec = 0;
  endtask
  logic [31:0] ret_addr [D+1];
  logic [31:0] cpc;
  initial begin
    idle();
    ifc.if2_ready_i = 1;
    rst = 1;
    tick(); tick();
    chk = 1;
    cmp("rst_pc", pc_o, 32'h8000_0000);
    cmp("rst_if1v", 32'(if1v_o), 0);
    cmp("rst_if2v", 32'(ifc.if2_valid_o), 0);
    cmp("rst_if2pc", ifc.if2_pc_o, 0);
    rst = 0;
    tick();
    cmp("boot_if1v", 32'(if1v_o), 1);
    cmp("boot_if2v", 32'(ifc.if2_valid_o), 0);
    tick();
    cmp("first_if2v", 32'(ifc.if2_valid_o), 1);
    cmp("first_if2pc", ifc.if2_pc_o, 32'h8000_0000);
    cmp("seq1", pc_o, 32'h8000_0008);
    tick();
    cmp("seq2", pc_o, 32'h8000_0010);
    redirect(32'h8000_0000);
    vld = 1; bt = 2'd0; bm = 2'b01; tgt = 32'h8000_0100;
    tick();
    cmp("nt_pc", pc_o, 32'h8000_0008);
    cmp("nt_taken", 32'(ifc.if2_pred_taken_o), 0);
    bm = 2'b10;
    tick();
    cmp("tk_pc", pc_o, 32'h8000_0100);
    cmp("tk_target", ifc.if2_pred_target_o, 32'h8000_0100);
    vld = 0;
    tick();
    cmp("tk_nobubble_if2v", 32'(ifc.if2_valid_o), 1);
    cmp("tk_nobubble_if2pc", ifc.if2_pc_o, 32'h8000_0100);
    redirect(32'h8000_0040);
    vld = 1; bt = 2'd1; idx = 1; tgt = 32'h8000_0200;
    tick();
    cmp("call_pc", pc_o, 32'h8000_0200);
    cmp("call_ptr", 32'(ifc.if2_ras_ptr_o), RAS_EN ? 32'd1 : 32'd0);
    bt = 2'd3; idx = 0; tgt = 32'h0;
    tick();
    cmp("ret_pc", pc_o, RAS_EN ? 32'h8000_0048 : 32'h0);
    cmp("ret_ptr", 32'(ifc.if2_ras_ptr_o), 0);
    vld = 0;
    ifc.if2_ready_i = 0;
    redirect(32'h8000_0040);
    tick();
    vld = 1; bt = 2'd1; idx = 0; tgt = 32'h8000_0300;
    repeat (3) begin
      tick();
      cmp("stall_pc", pc_o, 32'h8000_0048);
      cmp("stall_if2pc", ifc.if2_pc_o, 32'h8000_0040);
    end
    ifc.if2_ready_i = 1;
    tick();
    cmp("stall_rel_pc", pc_o, 32'h8000_0300);
    cmp("stall_rel_if2pc", ifc.if2_pc_o, 32'h8000_0048);
    cmp("stall_push_ptr", 32'(ifc.if2_ras_ptr_o), RAS_EN ? 32'd1 : 32'd0);
    bt = 2'd3; tgt = 32'h0;
    tick();
    cmp("ret2_pc", pc_o, RAS_EN ? 32'h8000_004C : 32'h0);
    ifc.if2_ready_i = 0;
    idle();
    flush = 1; flush_pc = 32'h1000; flush_ptr = 5'd3; dec = 1; dec_pc = 32'h2000;
    tick();
    cmp("flush_pc", pc_o, 32'h1000);
    cmp("flush_if2v", 32'(ifc.if2_valid_o), 0);
    idle();
    ifc.if2_ready_i = 1;
    tick();
    cmp("flush_if2pc", ifc.if2_pc_o, 32'h1000);
    cmp("flush_ptr", 32'(ifc.if2_ras_ptr_o), RAS_EN ? 32'd3 : 32'd0);
    redirect(32'h5000);
    for (int i = 0; i <= D; i++) begin
      cpc = (i == 0) ? 32'h5000 : 32'h6000 + 32'(i - 1) * 32'h100;
      vld = 1; bt = 2'd1; idx = i[0]; tgt = 32'h6000 + 32'(i) * 32'h100;
      ret_addr[i] = cpc + (idx ? 32'd4 : 32'd0) + 32'd4;
      tick();
    end
    for (int j = 0; j <= D; j++) begin
      vld = 1; bt = 2'd3; idx = 0; tgt = 32'hDEAD_0000;
      tick();
      cmp("ret_lifo", pc_o, (RAS_EN && j < D) ? ret_addr[D - j] : 32'hDEAD_0000);
    end
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom % 500) == 0;
      flush = ($urandom % 40) == 0;
      dec = ($urandom % 25) == 0;
      flush_pc = $urandom; dec_pc = $urandom; flush_ptr = 5'($urandom);
      vld = $urandom % 2; bt = 2'($urandom); bm = 2'($urandom); tgt = $urandom;
      idx = 1'($urandom); way = 1'($urandom);
      ifc.if2_ready_i = ($urandom % 4) != 0;
      tick();
    end
    rst = 0;
    idle();
    tick();
    @(negedge clk);
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
